// File: rtl/rr_index_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_index_arbiter
// Description : Round-robin arbiter that feeds a priority decoder. It samples
//               an N-bit level request vector and picks one requester fairly.
//               The winner's binary index is presented on a registered
//               valid/ready handshake. A presented index stays stable until
//               it is accepted. Winners are registered one cycle after the
//               request is seen, and can be accepted back-to-back, one per
//               cycle.
// Ports       :
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset (async assert)
//   req        in   N  level requests; bit i = requester i wants service
//   idx_valid  out  1  idx holds a granted requester index
//   idx_ready  in   1  downstream accepts idx this cycle
//   idx        out  M  binary index of granted requester, always < N
//   last_idx   out  M  index of most recently accepted grant
// Revision    : 1.0  initial release
// ============================================================================
module rr_index_arbiter #(
    parameter int N = 8,
    parameter int M = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [M-1:0] idx,
    output logic [M-1:0] last_idx
);

    // The pointer resets to the top requester, so the first search after
    // reset begins at requester 0.
    localparam logic [M-1:0] c_last_reset = M'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [M-1:0] r_idx;
    logic [M-1:0] w_idx_nxt;
    logic [M-1:0] r_last_idx;
    logic [M-1:0] w_last_nxt;

    logic         w_accept;
    logic [M-1:0] w_ptr;
    logic         w_hi_found;
    logic [M-1:0] w_hi_idx;
    logic         w_any;
    logic [M-1:0] w_lo_idx;
    logic [M-1:0] w_winner;

    assign w_accept = (r_state == S_HOLD) && idx_ready;

    // On a handshake the index being accepted becomes the new pointer
    // in the same edge. So the search starts from r_idx, not from the
    // stale r_last_idx. The only other time the search result is used
    // is in IDLE, where r_last_idx is the pointer.
    assign w_ptr = (r_state == S_HOLD) ? r_idx : r_last_idx;

    // Rotating search without a modulo:
    //   The first choice is the lowest set request strictly above the
    //   pointer.
    //   If there is none, the search wraps. The winner is then the lowest
    //   set request overall. That request is at or below the pointer.
    //   The pointer position itself is reached last.
    // Only bit positions 0..N-1 are examined. This means a wrap is
    // modulo N, and an index >= N can never be produced.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_any      = 1'b0;
        w_lo_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_any    = 1'b1;
                w_lo_idx = M'(j);
                if (M'(j) > w_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = M'(j);
                end
            end
        end
    end

    assign w_winner = w_hi_found ? w_hi_idx : w_lo_idx;

    // Next-state and next-data logic.
    // While HOLD is waiting on ready, all registers keep their values.
    // This holds even if the request that won has since dropped, so a
    // grant is never retracted.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last_idx;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_idx_nxt   = w_winner;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_last_nxt = r_idx;
                    if (w_any) begin
                        w_idx_nxt   = w_winner;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_last_idx <= c_last_reset;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_nxt;
        end
    end

    // Every output is taken straight from a register.
    assign idx_valid = (r_state == S_HOLD);
    assign idx       = r_idx;
    assign last_idx  = r_last_idx;

endmodule
`default_nettype wire
